// File: rtl/spi_counter_rx_if.sv
// spi_counter_rx_if: SPI bus between the counter master and the slave
// receiver.
//   sclk : SPI clock, mode 0 (idles low, data sampled on the rising edge)
//   mosi : serial data from master to slave, MSB first
//   cs_n : frame select, active low
//   miso : loopback data from slave to master
interface spi_counter_rx_if;
  logic sclk;
  logic mosi;
  logic cs_n;
  logic miso;

  modport master (output sclk, output mosi, output cs_n, input miso);
  modport slave  (input sclk, input mosi, input cs_n, output miso);
endinterface

// File: rtl/spi_counter_rx.sv
// spi_counter_rx: slave-side SPI receiver feeding the counter/FND path.
// Oversamples the asynchronous SPI bus on clk, rebuilds 16-bit frames and
// presents the low DATA_WIDTH bits as a registered word with a valid strobe.
// Malformed frames (short, or with extra clocks) raise o_frame_err instead.
//
// Optional feature: define SPI_COUNTER_RX_MISO_EN to shift the last accepted
// value back out on miso during each frame; otherwise miso is constant 0.
//
// Ports:
//   clk         : system clock (100 MHz)
//   reset       : synchronous, active-high reset
//   bus         : SPI bus (slave modport: sclk, mosi, cs_n in; miso out)
//   o_data      : last accepted counter value
//   o_valid     : one-cycle strobe, o_data was updated
//   o_frame_err : one-cycle strobe, a frame was rejected
//   o_busy      : a frame is in progress (RECV or FULL)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for cs_n to fall; bit counter and shift reg cleared
// RECV  | shifting in mosi on each sclk rising edge, fewer than 16 bits
// FULL  | 16 bits held; waiting for cs_n to rise, extra sclk = overrun
module spi_counter_rx #(
  parameter int DATA_WIDTH  = 14,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_counter_rx_if.slave       bus,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int SW = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [SW-1:0]          settle_q;
  logic                   armed_q;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, cs_rise, cs_fall;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [15:0]           shift_q, shift_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, err_d;
  logic                  unused_shift_msb;

  // Input synchronizers and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      settle_q  <= SETTLE_INIT;
      armed_q   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (settle_q != '0) settle_q <= settle_q - 1'b1;
      // Only arm once the real pin level has reached the end of the chain
      // and shows deselect; a select still held across reset belongs to a
      // discarded frame and must not look like a fresh falling edge.
      if (settle_q == '0 && cs_s) armed_q <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = armed_q & ~cs_s & cs_d;

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ovr_q       <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ovr_q       <= ovr_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ovr_d   = ovr_q;
    data_d  = o_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        ovr_d   = 1'b0;
        if (cs_fall) state_d = RECV;
      end
      RECV: begin
        if (cs_fall) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (cs_rise) begin
          // Zero bits is a select glitch and stays silent
          state_d = IDLE;
          err_d   = (cnt_q != 5'd0);
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], mosi_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15) state_d = FULL;
        end
      end
      FULL: begin
        if (cs_fall) begin
          state_d = RECV;
          cnt_d   = '0;
          shift_d = '0;
          ovr_d   = 1'b0;
        end else if (cs_rise) begin
          state_d = IDLE;
          if (ovr_q) begin
            err_d = 1'b1;
          end else begin
            data_d  = shift_q[DATA_WIDTH-1:0];
            valid_d = 1'b1;
          end
        end else if (sclk_rise) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

  // The frame MSB only matters for widths of 16; otherwise it is dropped
  assign unused_shift_msb = shift_q[15];

`ifdef SPI_COUNTER_RX_MISO_EN
  logic        sclk_fall;
  logic [15:0] tx_q;

  assign sclk_fall = ~sclk_s & sclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q <= '0;
    end else if (cs_fall) begin
      tx_q <= 16'(o_data);
    end else if (sclk_fall) begin
      tx_q <= {tx_q[14:0], 1'b0};
    end
  end

  assign bus.miso = o_busy & tx_q[15];
`else
  assign bus.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_counter_rx.sv
// tb_spi_counter_rx: directed and randomized frames checked against a
// frame-level reference model (bit count decides accept / reject / silent).
module tb_spi_counter_rx;
  localparam int DW = 14;
  localparam logic [15:0] MASK = 16'((1 << DW) - 1);

  typedef struct {
    bit          is_err;
    logic [15:0] data;
    int          lat;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] o_data;
  logic o_valid, o_frame_err, o_busy;

  spi_counter_rx_if bus ();

  spi_counter_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int data_glitch = 0;
  logic [DW-1:0] prev_data = '0;
  logic [15:0] model_data = '0;
  ev_t obs[$];
  ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, got, want);
    end
  endtask

  // Strobe monitor
  always @(negedge clk) begin
    if (o_valid === 1'b1 || o_frame_err === 1'b1) begin
      ev_t e;
      n_cmp++;
      assert (!(o_valid && o_frame_err)) else begin
        n_fail++;
        $error("FAIL strobe_exclusive: observed valid=%0b err=%0b, expected not both", o_valid, o_frame_err);
      end
      e.is_err = o_frame_err;
      e.data   = 16'(o_data);
      e.lat    = cyc - rise_cyc;
      obs.push_back(e);
    end
    if (!reset && o_data !== prev_data && o_valid !== 1'b1) data_glitch++;
    prev_data = o_data;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] miso_expect();
`ifdef SPI_COUNTER_RX_MISO_EN
    return model_data;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic clock_bits(input logic [31:0] bits, input int n, input int half,
                            output logic [15:0] mw);
    mw = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = bits[i];
      wait_cyc(half);
      if (n - 1 - i < 16) mw = {mw[14:0], bus.miso};
      bus.sclk = 1'b1;
      wait_cyc(half);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int half, input int gap);
    logic [15:0] mw;
    ev_t e;
    bus.cs_n = 1'b0;
    wait_cyc(4);
    check("busy_in_frame", o_busy, 1);
    clock_bits(bits, nbits, half, mw);
    wait_cyc(half);
    bus.cs_n = 1'b1;
    rise_cyc = cyc;
    if (nbits >= 16) check("miso_word", mw, miso_expect());
    if (nbits == 16) begin
      model_data = bits[15:0] & MASK;
      e.is_err = 1'b0;
      e.data   = model_data;
      e.lat    = 0;
      exp_q.push_back(e);
    end else if (nbits != 0) begin
      e.is_err = 1'b1;
      e.data   = '0;
      e.lat    = 0;
      exp_q.push_back(e);
    end
    wait_cyc(gap);
  endtask

  task automatic drain();
    ev_t o, e;
    int t;
    t = 0;
    while (obs.size() < exp_q.size() && t < 12) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("strobe_count", obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      check("strobe_kind", o.is_err, e.is_err);
      if (!e.is_err) check("strobe_data", o.data, e.data);
      check("strobe_latency_3_to_5", (o.lat >= 3 && o.lat <= 5), 1);
    end
    obs.delete();
    exp_q.delete();
    check("o_data", o_data, model_data);
    check("busy_after", o_busy, 0);
  endtask

  initial begin
    logic [15:0] mw;
    int nb, r;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    reset = 1'b1;
    wait_cyc(4);
    check("rst_o_data", o_data, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_frame_err", o_frame_err, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_miso", bus.miso, 0);
    reset = 1'b0;
    wait_cyc(6);

    // Single frame at clk/10
    send_frame(32'h0005, 16, 5, 6);
    drain();

    // Back to back with the minimum cs_n gap
    for (int v = 0; v < 4; v++) send_frame(32'(v), 16, 5, 4);
    drain();

    // Max display value, then a truncated frame
    send_frame(32'h270F, 16, 5, 6);
    drain();
    send_frame(32'h1A5, 9, 5, 6);
    drain();

    // 17 clocks (overrun), then a select pulse with no clocks
    send_frame(32'h1_2345, 17, 5, 6);
    drain();
    send_frame(32'h0, 0, 5, 6);
    drain();

    // Reset in the middle of a frame
    bus.cs_n = 1'b0;
    wait_cyc(4);
    clock_bits(32'h00AB, 8, 5, mw);
    reset = 1'b1;
    wait_cyc(2);
    check("midrst_o_data", o_data, 0);
    check("midrst_o_busy", o_busy, 0);
    check("midrst_o_valid", o_valid, 0);
    reset = 1'b0;
    clock_bits(32'h00CD, 8, 5, mw);
    wait_cyc(5);
    bus.cs_n = 1'b1;
    rise_cyc = cyc;
    model_data = '0;
    wait_cyc(4);
    drain();
    send_frame(32'h0042, 16, 5, 6);
    drain();

    // Loopback readback
    send_frame(32'h1234, 16, 5, 6);
    drain();
    send_frame(32'h0000, 16, 5, 6);
    drain();

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      nb = 16;
      else if (r == 6) nb = 0;
      else if (r == 7) nb = 17;
      else             nb = $urandom_range(1, 15);
      send_frame($urandom, nb, $urandom_range(4, 8), $urandom_range(4, 10));
      if ($urandom_range(0, 2) != 0) drain();
    end
    drain();

    check("o_data_only_changes_with_valid", data_glitch, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
